// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared types for the draw command path: scheduler states, queued command
// layout and per-vertex field offsets within the 48-bit coordinate word.
package gpu_draw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        SETTLE
    } sched_state_t;

    typedef struct packed {
        logic        is_tri;
        logic [47:0] coords;
    } draw_cmd_t;

    localparam int COORD_W = 8;
    localparam int X0      = 0;
    localparam int Y0      = 8;
    localparam int X1      = 16;
    localparam int Y1      = 24;
    localparam int X2      = 32;
    localparam int Y2      = 40;

endpackage

// File: rtl/draw_cmd_scheduler_if.sv
// Valid/ready command bus from the instruction decoder into the scheduler.
interface draw_cmd_scheduler_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_tri;
    logic [47:0] cmd_coords;

    modport master (output cmd_valid, output cmd_tri, output cmd_coords, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_tri, input cmd_coords, output cmd_ready);

endinterface

// File: rtl/draw_cmd_scheduler_fifo.sv
// Synchronous FIFO of draw commands; head is presented combinationally so a
// pop and the holding-register load happen on the same edge.
module draw_cmd_fifo
    import gpu_draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         push,
    input  draw_cmd_t                    push_data,
    input  logic                         pop,
    input  logic                         clear,
    output draw_cmd_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    draw_cmd_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    // clear wins over both push and pop so a flush leaves nothing behind
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Buffers decoder draw commands and issues them one at a time to the
// Bresenham controller, holding coordinates steady and counting completions.
module draw_cmd_scheduler
    import gpu_draw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    draw_cmd_scheduler_if.slave          cmd,
    input  logic                         flush,
    output logic                         bla_en,
    output logic                         vertice_num,
    output logic [47:0]                  coordinates,
    input  logic                         bla_done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [CNT_W-1:0]             prims_done
);

    sched_state_t     state_reg;
    draw_cmd_t        hold_reg;
    logic             bla_en_reg;
    logic [CNT_W-1:0] prims_reg;

    draw_cmd_t        push_data;
    draw_cmd_t        head;
    logic             full;
    logic             empty;
    logic             pop;

    assign push_data = '{is_tri: cmd.cmd_tri, coords: cmd.cmd_coords};
    assign pop       = (state_reg == IDLE) & ~empty & ~flush;

    draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (cmd.cmd_valid),
        .push_data (push_data),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign cmd.cmd_ready = ~full & ~flush;
    assign busy          = (state_reg != IDLE) | ~empty;
    assign bla_en        = bla_en_reg;
    assign vertice_num   = hold_reg.is_tri;
    assign coordinates   = hold_reg.coords;
    assign prims_done    = prims_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            hold_reg   <= '0;
            bla_en_reg <= 1'b0;
            prims_reg  <= '0;
        end else begin
            bla_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        hold_reg   <= head;
                        bla_en_reg <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: state_reg <= WAIT_DONE;
                WAIT_DONE: begin
                    if (bla_done) begin
                        prims_reg <= prims_reg + 1'b1;
                        state_reg <= SETTLE;
                    end
                end
                // one dead cycle while the controller leaves its done state
                SETTLE:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed and randomized stimulus against an edge-indexed behavioural model
// of the scheduler's queue, issue timing and completion count.
module tb_draw_cmd_scheduler;
    import gpu_draw_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;
    localparam int FCW   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             flush = 1'b0;
    logic             bla_done = 1'b0;
    logic             bla_en;
    logic             vertice_num;
    logic [47:0]      coordinates;
    logic             busy;
    logic [FCW-1:0]   fifo_count;
    logic [CNT_W-1:0] prims_done;

    draw_cmd_scheduler_if cmd_bus ();

    draw_cmd_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cmd         (cmd_bus),
        .flush       (flush),
        .bla_en      (bla_en),
        .vertice_num (vertice_num),
        .coordinates (coordinates),
        .bla_done    (bla_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .prims_done  (prims_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: queue contents plus the edge indices of the last issue and completion
    logic [48:0] q[$];
    logic [48:0] hold;
    bit          inflight;
    int          cur;
    int          pop_edge;
    int          done_edge;
    int          prims;
    int          issued;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold      = '0;
        inflight  = 1'b0;
        prims     = 0;
        pop_edge  = cur - 5;
        done_edge = cur - 2;
    endtask

    // called at a negedge: drive inputs, check outputs, advance the model by one edge
    task automatic step(input bit v, input bit t, input logic [47:0] c, input bit f, input bit d);
        int  n;
        bit  do_pop;
        bit  do_done;
        bit  acc;
        cmd_bus.cmd_valid  = v;
        cmd_bus.cmd_tri    = t;
        cmd_bus.cmd_coords = c;
        flush              = f;
        bla_done           = d;
        #1;
        check_val("cmd_ready",   64'(cmd_bus.cmd_ready), 64'((q.size() < DEPTH) && !f));
        check_val("bla_en",      64'(bla_en),      64'(cur == pop_edge));
        check_val("vertice_num", 64'(vertice_num), 64'(hold[48]));
        check_val("coordinates", 64'(coordinates), 64'(hold[47:0]));
        check_val("fifo_count",  64'(fifo_count),  64'(q.size()));
        check_val("busy",        64'(busy),        64'(inflight || (cur == done_edge) || (q.size() > 0)));
        check_val("prims_done",  64'(prims_done),  64'(prims % (1 << CNT_W)));

        n       = cur + 1;
        do_pop  = !inflight && (n >= done_edge + 2) && (q.size() > 0) && !f;
        do_done = inflight && (n >= pop_edge + 2) && d;
        acc     = v && (q.size() < DEPTH) && !f;
        if (do_done) begin
            prims++;
            inflight  = 1'b0;
            done_edge = n;
        end
        if (f) begin
            q.delete();
        end else begin
            if (do_pop) begin
                hold     = q.pop_front();
                inflight = 1'b1;
                pop_edge = n;
                issued++;
                $display("issue %0d: tri=%0d coords=%012h", issued, hold[48], hold[47:0]);
            end
            if (acc) q.push_back({t, c});
        end
        cur = n;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 48'h0, 1'b0, 1'b0);
    endtask

    // completes everything outstanding, bounded so a stuck design still reaches the summary
    task automatic drain();
        int i;
        for (i = 0; i < 200 && (inflight || q.size() > 0); i++)
            step(1'b0, 1'b0, 48'h0, 1'b0, (i % 4) == 3);
        check_val("drain_done", 64'(inflight || q.size() > 0), 64'(0));
    endtask

    task automatic push_rand(input bit f);
        logic [47:0] c;
        c = {16'($urandom), 32'($urandom)};
        step(1'b1, 1'($urandom), c, f, 1'b0);
    endtask

    task automatic do_reset();
        cmd_bus.cmd_valid = 1'b0;
        flush             = 1'b0;
        bla_done          = 1'b0;
        n_rst             = 1'b0;
        #1;
        check_val("rst_bla_en",      64'(bla_en),            64'(0));
        check_val("rst_vertice_num", 64'(vertice_num),       64'(0));
        check_val("rst_coordinates", 64'(coordinates),       64'(0));
        check_val("rst_cmd_ready",   64'(cmd_bus.cmd_ready), 64'(1));
        check_val("rst_busy",        64'(busy),              64'(0));
        check_val("rst_fifo_count",  64'(fifo_count),        64'(0));
        check_val("rst_prims_done",  64'(prims_done),        64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pv;
        int pd;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_tri    = 1'b0;
        cmd_bus.cmd_coords = '0;
        cur    = 0;
        issued = 0;
        @(negedge clk);
        do_reset();

        // single line, completed 20 cycles after it starts
        step(1'b1, 1'b0, 48'h0000_3C28_1E0A, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        idle(3);
        check_val("line_prims", 64'(prims_done), 64'(1));

        // five back-to-back commands with completion held off, then released one at a time
        for (int i = 0; i < 5; i++) push_rand(1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
            idle(4);
        end
        check_val("five_prims", 64'(prims_done), 64'(6));

        // push lands on the same edge as a pop with one command queued
        push_rand(1'b0);
        idle(3);
        push_rand(1'b0);
        idle(2);
        step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        idle(1);
        push_rand(1'b0);
        drain();

        // flush with three queued while one is in flight
        for (int i = 0; i < 4; i++) push_rand(1'b0);
        idle(2);
        step(1'b0, 1'b0, 48'h0, 1'b1, 1'b0);
        idle(2);
        drain();

        // spurious completions in IDLE and SETTLE
        step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        push_rand(1'b0);
        idle(3);
        step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        idle(3);
        drain();

        // reset while waiting with two queued
        for (int i = 0; i < 3; i++) push_rand(1'b0);
        idle(2);
        do_reset();
        idle(5);

        // randomized traffic; counter width is small enough to wrap several times
        pv = 50;
        pd = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                pv = $urandom_range(10, 90);
                pd = $urandom_range(5, 60);
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < pv, 1'($urandom),
                     {16'($urandom), 32'($urandom)},
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < pd);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_cmd_scheduler.md
# draw_cmd_scheduler

Queues line and triangle draw commands from the instruction decoder and issues them one at a time to `bresenham_controller` over its `bla_en`/`bla_done` handshake. It buffers up to DEPTH commands so the decoder keeps running while edges rasterize. It holds each command's coordinates stable for the whole draw and counts completed primitives.

## Interface
- DEPTH, 4: command FIFO entries, ≥2, power of two.
- CNT_W, 16: width of the completed-primitive counter.
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  scheduler accepts; transfer on clk edge with cmd_valid&cmd_ready.
- cmd_tri  in  1  1 = triangle (3 vertices), 0 = line (2 vertices).
- cmd_coords  in  48  {y2,x2,y1,x1,y0,x0}, 8 bits each, x0 at [7:0].
- flush  in  1  discard all queued (not yet issued) commands.
- bla_en  out  1  start pulse to `bresenham_controller`.
- vertice_num  out  1  cmd_tri of the issued command.
- coordinates  out  48  cmd_coords of the issued command.
- bla_done  in  1  one-cycle completion pulse from `bresenham_controller`.
- busy  out  1  state≠IDLE or FIFO non-empty.
- fifo_count  out  $clog2(DEPTH+1)  queued entries, excluding the in-flight command.
- prims_done  out  CNT_W  completed primitives, wraps modulo 2^CNT_W.

## Operation
- **FIFO**
  - Synchronous, first-in first-out.
  - cmd_ready = !full & !flush.
  - Push and pop in the same cycle are legal; fifo_count is unchanged.
  - Pointers wrap modulo DEPTH.
- **Holding register** {tri, coords} drives vertice_num/coordinates.
  - Loaded only on pop.
  - Otherwise holds its value, including after return to IDLE.
- **FSM**
  - IDLE: if FIFO non-empty, pop head into the holding register and go to ISSUE; else stay.
  - ISSUE: bla_en=1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: on bla_done=1, increment prims_done and go to SETTLE; else stay. There is no timeout.
  - SETTLE: one cycle (downstream is leaving its done state), then go to IDLE.
- bla_done outside WAIT_DONE is ignored: no count, no transition.
- **flush**
  - Empties the FIFO at the next edge, taking priority over a simultaneous push or pop.
  - Does not affect the FSM, the holding register or prims_done. The in-flight command completes normally.
  - Asserted in IDLE with a non-empty FIFO: no pop occurs.
- A push while full is impossible by handshake (cmd_ready=0). Data is ignored and the FIFO is unchanged.

## Timing
- **Reset values:** state IDLE, bla_en 0, vertice_num 0, coordinates 0, cmd_ready 1, busy 0, fifo_count 0, prims_done 0, FIFO empty.
- **Issue latency**, command accepted at edge E0 with the FSM in IDLE and the FIFO empty:
  - E1: pop, state becomes ISSUE.
  - Cycle E1–E2: bla_en=1.
  - E2: state becomes WAIT_DONE.
  - bla_en is high two edges after acceptance.
- **Back-to-back**, bla_done sampled at edge Ek:
  - Ek+1: SETTLE→IDLE.
  - Ek+2: pop.
  - Next bla_en high in cycle Ek+2–Ek+3.
  - Minimum gap from bla_done to next bla_en is 2 idle cycles.
- bla_en is never high for two consecutive cycles. This guarantees the downstream block does not re-trigger on a level.
- vertice_num/coordinates are stable from the ISSUE cycle through SETTLE.
- prims_done updates at the edge that samples bla_done. prims_done = 2^CNT_W−1 wraps to 0.
- busy is combinational from state and FIFO count. It is 1 in the cycle after acceptance.
- Reset mid-operation: all state returns to reset values immediately. Queued commands are lost. The downstream block shares n_rst.

## Structure
- Package `gpu_draw_pkg`:
  - sched_state_t enum {IDLE, ISSUE, WAIT_DONE, SETTLE}.
  - draw_cmd_t packed struct {tri, coords[47:0]}.
  - Vertex field offsets X0/Y0/X1/Y1/X2/Y2 (0, 8, …, 40) and COORD_W=8.
- Sub-module `draw_cmd_fifo`: parameterized synchronous FIFO of draw_cmd_t with push, pop, clear, full, empty, count.
- Top level: FSM, holding register, counter.

## Test plan
- Reset, then one line {tri=0, coords=48'h0000_3C28_1E0A}: bla_en pulses once 2 edges after acceptance; vertice_num=0; coordinates=48'h0000_3C28_1E0A until SETTLE; bla_done after 20 cycles gives prims_done=1 and busy=0 two cycles later.
- Push 5 commands back-to-back with DEPTH=4 while bla_done is held off: cmd_ready drops after the 4+1th acceptance (1 in flight + 4 queued); fifo_count=4; pulsing bla_done 5 times issues all 5 in order with ≥2-cycle gaps; prims_done=5.
- Simultaneous push and pop in IDLE with 1 queued: fifo_count stays 1; order is preserved.
- flush with 3 queued during WAIT_DONE: fifo_count becomes 0 next edge; the in-flight command completes; no further bla_en; prims_done increments by 1 only.
- Spurious bla_done in IDLE and in SETTLE: no count change, no state change.
- n_rst asserted in WAIT_DONE with 2 queued: all outputs return to reset values asynchronously; no bla_en after release until new commands arrive.
